// File: rtl/screen_framebuffer_pkg.sv
// ---------------------------------------------------------------------------
// screen_framebuffer_pkg
// Shared definitions for the ST7735 framebuffer slice: default geometry,
// helpers that derive coordinate / bank widths from the geometry, and the
// fill-engine state encoding.
// ---------------------------------------------------------------------------
package screen_framebuffer_pkg;

  localparam int DEF_WIDTH     = 128;
  localparam int DEF_HEIGHT    = 128;
  localparam int DEF_PIX_W     = 16;
  localparam int DEF_BANK_ROWS = 64;

  // Width needed to index v items, never less than one bit so that
  // degenerate geometries still produce legal vectors.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int num_banks(input int height, input int bank_rows);
    return (height + bank_rows - 1) / bank_rows;
  endfunction

  localparam int DEF_XW        = clog2_min1(DEF_WIDTH);
  localparam int DEF_YW        = clog2_min1(DEF_HEIGHT);
  localparam int DEF_NUM_BANKS = num_banks(DEF_HEIGHT, DEF_BANK_ROWS);
  localparam int DEF_BANK_AW   = clog2_min1(DEF_BANK_ROWS) + DEF_XW;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fb_state_t;

endpackage

// File: rtl/screen_framebuffer_if.sv
// ---------------------------------------------------------------------------
// screen_framebuffer_if
// Bundles the framebuffer's write port, read port and fill-engine controls.
//   master : drawing logic / refresh controller side (drives requests)
//   slave  : framebuffer side (drives ready, read data and fill status)
// ---------------------------------------------------------------------------
interface screen_framebuffer_if #(
  parameter int XW    = 7,
  parameter int YW    = 7,
  parameter int PIX_W = 16
);
  logic             wr_en;
  logic [XW-1:0]    wr_x;
  logic [YW-1:0]    wr_y;
  logic [PIX_W-1:0] wr_data;
  logic             wr_ready;

  logic             rd_en;
  logic [XW-1:0]    rd_x;
  logic [YW-1:0]    rd_y;
  logic             rd_ready;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;

  logic             fill_start;
  logic [PIX_W-1:0] fill_color;
  logic             fill_busy;
  logic             fill_done;

  modport master (
    output wr_en, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y, fill_start, fill_color,
    input  wr_ready, rd_ready, rd_data, rd_valid, fill_busy, fill_done
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y, fill_start, fill_color,
    output wr_ready, rd_ready, rd_data, rd_valid, fill_busy, fill_done
  );
endinterface

// File: rtl/screen_framebuffer_bank.sv
// ---------------------------------------------------------------------------
// framebuffer_bank
// Single-port synchronous RAM, read-first, one-cycle registered read.
//   clk   : clock
//   we    : write enable for addr
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : data at the address presented on the previous edge
// Shaped so a 16K x 16 instance maps onto one SB_SPRAM256KA.
// ---------------------------------------------------------------------------
module framebuffer_bank #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/screen_framebuffer.sv
// ---------------------------------------------------------------------------
// screen_framebuffer
// Multi-bank pixel store between the drawing logic and the screen refresh
// controller, with a hardware fill engine that paints the whole frame.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : write port, read port (1-cycle latency) and fill controls
// Reads always win a bank conflict so the refresh path never stalls; a write
// to a different bank proceeds in the same cycle. Out-of-range writes are
// accepted and dropped, out-of-range reads return zero with rd_valid high.
// ---------------------------------------------------------------------------
module screen_framebuffer
  import screen_framebuffer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int BANK_ROWS = DEF_BANK_ROWS
) (
  input logic                clk,
  input logic                rst_n,
  screen_framebuffer_if.slave bus
);
  localparam int XW = clog2_min1(WIDTH);
  localparam int YW = clog2_min1(HEIGHT);
  localparam int RW = clog2_min1(BANK_ROWS);
  localparam int NB = num_banks(HEIGHT, BANK_ROWS);
  localparam int AW = RW + XW;

  localparam logic [XW:0]   WIDTH_L  = (XW+1)'(WIDTH);
  localparam logic [YW:0]   HEIGHT_L = (YW+1)'(HEIGHT);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(BANK_ROWS - 1);

  fb_state_t        state_reg;
  logic [RW-1:0]    fill_row_reg;
  logic [XW-1:0]    fill_x_reg;
  logic [PIX_W-1:0] fill_color_reg;
  logic             fill_busy_reg;
  logic             fill_done_reg;
  logic             rd_valid_reg;
  logic             rd_in_range_reg;
  logic [YW-1:0]    rd_bank_reg;

  logic             idle;
  logic [YW-1:0]    rd_bank, wr_bank;
  logic [AW-1:0]    rd_addr, wr_addr, fill_addr;
  logic             rd_in_range, wr_in_range;
  logic             rd_fire, wr_fire;
  logic             fill_row_wrap, fill_at_last, fill_next_last;
  logic [XW-1:0]    fill_x_next;
  logic [RW-1:0]    fill_row_next;
  logic [PIX_W-1:0] bank_rdata [NB];

  assign idle    = (state_reg == ST_IDLE);
  assign rd_bank = bus.rd_y >> RW;
  assign wr_bank = bus.wr_y >> RW;
  assign rd_addr = {bus.rd_y[RW-1:0], bus.rd_x};
  assign wr_addr = {bus.wr_y[RW-1:0], bus.wr_x};
  assign fill_addr = {fill_row_reg, fill_x_reg};

  assign rd_in_range = ({1'b0, bus.rd_x} < WIDTH_L) && ({1'b0, bus.rd_y} < HEIGHT_L);
  assign wr_in_range = ({1'b0, bus.wr_x} < WIDTH_L) && ({1'b0, bus.wr_y} < HEIGHT_L);

  assign bus.rd_ready = idle;
  assign bus.wr_ready = idle && !(bus.rd_en && (rd_bank == wr_bank));

  assign rd_fire = bus.rd_en && bus.rd_ready;
  // Out-of-range writes complete the handshake but never reach a bank.
  assign wr_fire = bus.wr_en && bus.wr_ready && wr_in_range;

  // Fill counter walks columns 0..WIDTH-1 then moves to the next row, so
  // unused column codes (x >= WIDTH) are skipped.
  assign fill_row_wrap  = (fill_x_reg == X_LAST);
  assign fill_at_last   = fill_row_wrap && (fill_row_reg == ROW_LAST);
  assign fill_x_next    = fill_row_wrap ? '0 : fill_x_reg + 1'b1;
  assign fill_row_next  = fill_row_wrap ? fill_row_reg + 1'b1 : fill_row_reg;
  assign fill_next_last = (fill_x_next == X_LAST) && (fill_row_next == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      fill_row_reg   <= '0;
      fill_x_reg     <= '0;
      fill_color_reg <= '0;
      fill_busy_reg  <= 1'b0;
      fill_done_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          fill_done_reg <= 1'b0;
          if (bus.fill_start) begin
            fill_color_reg <= bus.fill_color;
            fill_row_reg   <= '0;
            fill_x_reg     <= '0;
            fill_busy_reg  <= 1'b1;
            state_reg      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_at_last) begin
            fill_busy_reg <= 1'b0;
            fill_done_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end else begin
            fill_x_reg    <= fill_x_next;
            fill_row_reg  <= fill_row_next;
            // Registered so the pulse lines up with the final-address cycle.
            fill_done_reg <= fill_next_last;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg    <= 1'b0;
      rd_in_range_reg <= 1'b0;
      rd_bank_reg     <= '0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) begin
        rd_in_range_reg <= rd_in_range;
        rd_bank_reg     <= rd_bank;
      end
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    localparam logic [YW-1:0] BANK_ID = YW'(gi);
    logic             we;
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] wdata;

    // The single RAM port is owned by fill, then a read, then a write.
    always_comb begin
      we    = 1'b0;
      addr  = rd_addr;
      wdata = bus.wr_data;
      if (!idle) begin
        we    = 1'b1;
        addr  = fill_addr;
        wdata = fill_color_reg;
      end else if (rd_fire && (rd_bank == BANK_ID)) begin
        addr = rd_addr;
      end else if (wr_fire && (wr_bank == BANK_ID)) begin
        we   = 1'b1;
        addr = wr_addr;
      end
    end

    framebuffer_bank #(.AW(AW), .DW(PIX_W)) u_bank (
      .clk   (clk),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (bank_rdata[gi])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    if (rd_valid_reg && rd_in_range_reg) begin
      for (int i = 0; i < NB; i++) begin
        if (rd_bank_reg == YW'(i)) bus.rd_data = bank_rdata[i];
      end
    end
  end

  assign bus.rd_valid  = rd_valid_reg;
  assign bus.fill_busy = fill_busy_reg;
  assign bus.fill_done = fill_done_reg;

endmodule

// File: tb/tb_screen_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_screen_framebuffer
// Default 128x128 framebuffer checked against a plain pixel-array model, plus
// a 130x100 build that exercises out-of-range coordinates.
// ---------------------------------------------------------------------------
module tb_screen_framebuffer;
  localparam int W  = 128;
  localparam int H  = 128;
  localparam int PW = 16;
  localparam int BR = 64;
  localparam int XW = 7;
  localparam int YW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_framebuffer_if #(.XW(XW), .YW(YW), .PIX_W(PW)) a();
  screen_framebuffer_if #(.XW(8), .YW(7), .PIX_W(PW)) b();

  screen_framebuffer #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .BANK_ROWS(BR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  screen_framebuffer #(.WIDTH(130), .HEIGHT(100), .PIX_W(PW), .BANK_ROWS(BR)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model [H][W];
  bit          known [H][W];
  int wq_x[$];
  int wq_y[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a.wr_en = 0; a.rd_en = 0; a.fill_start = 0;
    a.wr_x = '0; a.wr_y = '0; a.wr_data = '0;
    a.rd_x = '0; a.rd_y = '0; a.fill_color = '0;
  endtask

  task automatic idle_b();
    b.wr_en = 0; b.rd_en = 0; b.fill_start = 0;
    b.wr_x = '0; b.wr_y = '0; b.wr_data = '0;
    b.rd_x = '0; b.rd_y = '0; b.fill_color = '0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (a.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got=%b want=0", a.rd_valid); end
    n_cmp++; if (a.rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data got=%h want=0000", a.rd_data); end
    n_cmp++; if (a.fill_busy !== 1'b0 || a.fill_done !== 1'b0) begin n_bad++; $display("FAIL reset_fill got busy=%b done=%b want 0/0", a.fill_busy, a.fill_done); end
    n_cmp++; if (a.rd_ready !== 1'b1 || a.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got rd=%b wr=%b want 1/1", a.rd_ready, a.wr_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    $display("reset: checked");
  endtask

  task automatic test_write_read();
    a.wr_en = 1; a.wr_x = 5; a.wr_y = 3; a.wr_data = 16'hF800;
    #1;
    n_cmp++; if (a.wr_ready !== 1'b1) begin n_bad++; $display("FAIL wr53_ready got=%b want=1", a.wr_ready); end
    tick();
    model[3][5] = 16'hF800; known[3][5] = 1; wq_x.push_back(5); wq_y.push_back(3);
    a.wr_en = 0; a.rd_en = 1; a.rd_x = 5; a.rd_y = 3;
    tick();
    a.rd_en = 0;
    n_cmp++; if (a.rd_valid !== 1'b1 || a.rd_data !== 16'hF800) begin n_bad++; $display("FAIL rd53 got valid=%b data=%h want 1/f800", a.rd_valid, a.rd_data); end
    tick();
    n_cmp++; if (a.rd_valid !== 1'b0 || a.rd_data !== 16'h0) begin n_bad++; $display("FAIL rd_idle got valid=%b data=%h want 0/0000", a.rd_valid, a.rd_data); end
    $display("write_read: wr(5,3)=f800 rd=%h", a.rd_data);
  endtask

  task automatic test_bank_conflict();
    logic [15:0] v0, v1;
    v0 = 16'($urandom); v1 = 16'($urandom);
    a.wr_en = 1; a.wr_x = 0; a.wr_y = 10; a.wr_data = v0;
    tick();
    model[10][0] = v0; known[10][0] = 1; wq_x.push_back(0); wq_y.push_back(10);
    a.rd_en = 1; a.rd_x = 0; a.rd_y = 10;
    a.wr_en = 1; a.wr_x = 1; a.wr_y = 20; a.wr_data = v1;
    #1;
    n_cmp++; if (a.wr_ready !== 1'b0 || a.rd_ready !== 1'b1) begin n_bad++; $display("FAIL conflict_ready got rd=%b wr=%b want 1/0", a.rd_ready, a.wr_ready); end
    tick();
    a.rd_en = 0;
    n_cmp++; if (a.rd_valid !== 1'b1 || a.rd_data !== v0) begin n_bad++; $display("FAIL conflict_read got valid=%b data=%h want 1/%h", a.rd_valid, a.rd_data, v0); end
    #1;
    n_cmp++; if (a.wr_ready !== 1'b1) begin n_bad++; $display("FAIL conflict_retry_ready got=%b want=1", a.wr_ready); end
    tick();
    model[20][1] = v1; known[20][1] = 1; wq_x.push_back(1); wq_y.push_back(20);
    a.wr_en = 0; a.rd_en = 1; a.rd_x = 1; a.rd_y = 20;
    tick();
    a.rd_en = 0;
    n_cmp++; if (a.rd_data !== v1) begin n_bad++; $display("FAIL conflict_retry_data got=%h want=%h", a.rd_data, v1); end
    $display("bank_conflict: rd(0,10)=%h wr(1,20)=%h", v0, v1);
  endtask

  task automatic test_diff_banks();
    logic [15:0] v;
    v = 16'($urandom);
    a.rd_en = 1; a.rd_x = 0; a.rd_y = 10;
    a.wr_en = 1; a.wr_x = 0; a.wr_y = 100; a.wr_data = v;
    #1;
    n_cmp++; if (a.wr_ready !== 1'b1 || a.rd_ready !== 1'b1) begin n_bad++; $display("FAIL diffbank_ready got rd=%b wr=%b want 1/1", a.rd_ready, a.wr_ready); end
    tick();
    model[100][0] = v; known[100][0] = 1; wq_x.push_back(0); wq_y.push_back(100);
    n_cmp++; if (a.rd_data !== model[10][0]) begin n_bad++; $display("FAIL diffbank_read got=%h want=%h", a.rd_data, model[10][0]); end
    a.wr_en = 0; a.rd_y = 100;
    tick();
    a.rd_en = 0;
    n_cmp++; if (a.rd_valid !== 1'b1 || a.rd_data !== v) begin n_bad++; $display("FAIL diffbank_write got valid=%b data=%h want 1/%h", a.rd_valid, a.rd_data, v); end
    $display("diff_banks: wr(0,100)=%h readback=%h", v, a.rd_data);
  endtask

  task automatic test_random_traffic();
    int rx, ry, wx, wy, k, bad0;
    bit rd, wr, exp_wr, exp_known;
    logic [15:0] wd, exp_d;
    bad0 = n_bad;
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(1)); wr = 1'($urandom_range(1));
      if (wq_x.size() > 0 && $urandom_range(1) == 1) begin
        k = $urandom_range(wq_x.size() - 1); rx = wq_x[k]; ry = wq_y[k];
      end else begin
        rx = $urandom_range(W - 1); ry = $urandom_range(H - 1);
      end
      wx = $urandom_range(W - 1); wy = $urandom_range(H - 1); wd = 16'($urandom);
      a.rd_en = rd; a.rd_x = XW'(rx); a.rd_y = YW'(ry);
      a.wr_en = wr; a.wr_x = XW'(wx); a.wr_y = YW'(wy); a.wr_data = wd;
      #1;
      exp_wr = !(rd && (ry / BR == wy / BR));
      n_cmp++; if (a.wr_ready !== exp_wr || a.rd_ready !== 1'b1) begin n_bad++; $display("FAIL rand_ready i=%0d got wr=%b rd=%b want %b/1", i, a.wr_ready, a.rd_ready, exp_wr); end
      exp_known = known[ry][rx]; exp_d = model[ry][rx];
      if (wr && exp_wr) begin
        model[wy][wx] = wd; known[wy][wx] = 1; wq_x.push_back(wx); wq_y.push_back(wy);
      end
      tick();
      n_cmp++; if (a.rd_valid !== rd) begin n_bad++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, a.rd_valid, rd); end
      if (rd && exp_known) begin
        n_cmp++; if (a.rd_data !== exp_d) begin n_bad++; $display("FAIL rand_data i=%0d (%0d,%0d) got=%h want=%h", i, rx, ry, a.rd_data, exp_d); end
      end else if (!rd) begin
        n_cmp++; if (a.rd_data !== 16'h0) begin n_bad++; $display("FAIL rand_idle_data i=%0d got=%h want=0000", i, a.rd_data); end
      end
    end
    idle_a();
    tick();
    $display("random_traffic: 400 cycles, %0d new failures", n_bad - bad0);
  endtask

  task automatic test_out_of_range();
    int rx [6] = '{5, 130, 200, 5, 129, 255};
    int ry [6] = '{3, 0, 3, 100, 99, 127};
    logic [15:0] ev [6];
    logic [15:0] d1, d3;
    d1 = 16'($urandom); d3 = 16'($urandom);
    ev = '{d1, 16'h0, 16'h0, 16'h0, d3, 16'h0};
    b.wr_en = 1; b.wr_x = 5; b.wr_y = 3; b.wr_data = d1;
    tick();
    b.wr_x = 200; b.wr_y = 3; b.wr_data = ~d1;
    #1;
    n_cmp++; if (b.wr_ready !== 1'b1) begin n_bad++; $display("FAIL oor_wr_ready got=%b want=1", b.wr_ready); end
    tick();
    b.wr_x = 5; b.wr_y = 100; b.wr_data = ~d1;
    tick();
    b.wr_x = 129; b.wr_y = 99; b.wr_data = d3;
    tick();
    b.wr_en = 0;
    for (int i = 0; i < 6; i++) begin
      b.rd_en = 1; b.rd_x = 8'(rx[i]); b.rd_y = 7'(ry[i]);
      tick();
      n_cmp++; if (b.rd_valid !== 1'b1 || b.rd_data !== ev[i]) begin n_bad++; $display("FAIL oor_read (%0d,%0d) got valid=%b data=%h want 1/%h", rx[i], ry[i], b.rd_valid, b.rd_data, ev[i]); end
      $display("out_of_range: rd(%0d,%0d)=%h", rx[i], ry[i], b.rd_data);
    end
    idle_b();
    tick();
  endtask

  task automatic test_fill();
    int busy_cnt, done_cnt, done_idx, viol, bad0;
    bit timeout;
    logic [15:0] exp_d;
    int rx, ry;
    busy_cnt = 0; done_cnt = 0; done_idx = 0; viol = 0; timeout = 1;
    a.fill_start = 1; a.fill_color = 16'h07E0;
    #1;
    n_cmp++; if (a.fill_busy !== 1'b0) begin n_bad++; $display("FAIL fill_busy_early got=%b want=0", a.fill_busy); end
    tick();
    a.fill_start = 0;
    for (int c = 0; c < 9000; c++) begin
      if (a.fill_busy !== 1'b1) begin timeout = 0; break; end
      busy_cnt++;
      if (a.fill_done === 1'b1) begin done_cnt++; done_idx = busy_cnt; end
      a.rd_en = 1'($urandom_range(1)); a.wr_en = 1'($urandom_range(1));
      a.rd_x = XW'($urandom); a.rd_y = YW'($urandom);
      a.wr_x = XW'($urandom); a.wr_y = YW'($urandom); a.wr_data = 16'($urandom);
      a.fill_start = (c == 100); a.fill_color = (c == 100) ? 16'h1234 : 16'h07E0;
      #1;
      if (a.rd_ready !== 1'b0 || a.wr_ready !== 1'b0) viol++;
      tick();
    end
    idle_a();
    n_cmp++; if (timeout) begin n_bad++; $display("FAIL fill_timeout busy still high after 9000 cycles"); end
    n_cmp++; if (busy_cnt != BR * W) begin n_bad++; $display("FAIL fill_busy_cycles got=%0d want=%0d", busy_cnt, BR * W); end
    n_cmp++; if (done_cnt != 1 || done_idx != BR * W) begin n_bad++; $display("FAIL fill_done_pulse got count=%0d at=%0d want 1 at %0d", done_cnt, done_idx, BR * W); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL fill_ready_low got %0d cycles with ready high want 0", viol); end
    n_cmp++; if (a.fill_done !== 1'b0 || a.rd_ready !== 1'b1) begin n_bad++; $display("FAIL fill_after got done=%b rd_ready=%b want 0/1", a.fill_done, a.rd_ready); end
    $display("fill: busy=%0d cycles done_pulses=%0d", busy_cnt, done_cnt);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin model[y][x] = 16'h07E0; known[y][x] = 1; end
    bad0 = n_bad;
    for (int i = 0; i < 200; i++) begin
      rx = $urandom_range(W - 1); ry = $urandom_range(H - 1);
      exp_d = model[ry][rx];
      a.rd_en = 1; a.rd_x = XW'(rx); a.rd_y = YW'(ry);
      tick();
      n_cmp++; if (a.rd_valid !== 1'b1 || a.rd_data !== exp_d) begin n_bad++; $display("FAIL fill_read (%0d,%0d) got valid=%b data=%h want 1/%h", rx, ry, a.rd_valid, a.rd_data, exp_d); end
    end
    idle_a();
    tick();
    $display("fill: 200 random reads, %0d failures", n_bad - bad0);
  endtask

  task automatic test_back_to_back();
    int xs [24];
    int ys [24];
    logic [15:0] d;
    for (int i = 0; i < 24; i++) begin
      xs[i] = $urandom_range(W - 1); ys[i] = $urandom_range(H - 1); d = 16'($urandom);
      a.wr_en = 1; a.wr_x = XW'(xs[i]); a.wr_y = YW'(ys[i]); a.wr_data = d;
      #1;
      n_cmp++; if (a.wr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_ready i=%0d got=%b want=1", i, a.wr_ready); end
      model[ys[i]][xs[i]] = d;
      tick();
    end
    a.wr_en = 0;
    for (int i = 0; i < 24; i++) begin
      a.rd_en = 1; a.rd_x = XW'(xs[i]); a.rd_y = YW'(ys[i]);
      tick();
      n_cmp++; if (a.rd_valid !== 1'b1 || a.rd_data !== model[ys[i]][xs[i]]) begin n_bad++; $display("FAIL b2b_read i=%0d got valid=%b data=%h want 1/%h", i, a.rd_valid, a.rd_data, model[ys[i]][xs[i]]); end
      $display("back_to_back: rd(%0d,%0d)=%h", xs[i], ys[i], a.rd_data);
    end
    idle_a();
    tick();
  endtask

  task automatic test_reset_inflight();
    a.rd_en = 1; a.rd_x = 5; a.rd_y = 3;
    tick();
    a.rd_en = 0;
    n_cmp++; if (a.rd_valid !== 1'b1) begin n_bad++; $display("FAIL inflight_valid got=%b want=1", a.rd_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (a.rd_valid !== 1'b0 || a.rd_data !== 16'h0) begin n_bad++; $display("FAIL inflight_reset got valid=%b data=%h want 0/0000", a.rd_valid, a.rd_data); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    $display("reset_inflight: rd_valid cleared");
  endtask

  task automatic test_reset_midfill();
    int done_seen, busy_seen;
    done_seen = 0; busy_seen = 0;
    a.fill_start = 1; a.fill_color = 16'hAAAA;
    tick();
    a.fill_start = 0;
    repeat (200) tick();
    n_cmp++; if (a.fill_busy !== 1'b1) begin n_bad++; $display("FAIL midfill_busy got=%b want=1", a.fill_busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a.fill_busy !== 1'b0 || a.fill_done !== 1'b0) begin n_bad++; $display("FAIL midfill_abort got busy=%b done=%b want 0/0", a.fill_busy, a.fill_done); end
    n_cmp++; if (a.rd_ready !== 1'b1) begin n_bad++; $display("FAIL midfill_rd_ready got=%b want=1", a.rd_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a.fill_done !== 1'b0) done_seen++;
      if (a.fill_busy !== 1'b0) busy_seen++;
    end
    n_cmp++; if (done_seen != 0 || busy_seen != 0) begin n_bad++; $display("FAIL midfill_after got done=%0d busy=%0d cycles want 0/0", done_seen, busy_seen); end
    n_cmp++; if (a.rd_ready !== 1'b1 || a.wr_ready !== 1'b1) begin n_bad++; $display("FAIL midfill_ready got rd=%b wr=%b want 1/1", a.rd_ready, a.wr_ready); end
    $display("reset_midfill: aborted, rd_ready=%b", a.rd_ready);
  endtask

  initial begin
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin model[y][x] = 16'h0; known[y][x] = 0; end
    idle_a();
    idle_b();
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_bank_conflict();
    test_diff_banks();
    test_random_traffic();
    test_out_of_range();
    test_fill();
    test_back_to_back();
    test_reset_inflight();
    test_reset_midfill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/screen_framebuffer.md
# screen_framebuffer

Parametrised, multi-bank pixel framebuffer for the ST7735 screen path. Stores WIDTH×HEIGHT pixels of PIX_W bits across NUM_BANKS single-port synchronous RAM banks. Provides a write port and a read port with ready handshakes, parallel access when they target different banks, and a hardware fill engine that clears the whole frame to one colour. Sits between the drawing logic (writer) and the screen refresh controller (reader).

## Interface
- WIDTH, 128: pixels per row; XW = clog2(WIDTH).
- HEIGHT, 128: rows; YW = clog2(HEIGHT).
- PIX_W, 16: bits per pixel.
- BANK_ROWS, 64: rows per bank, power of two; NUM_BANKS = ceil(HEIGHT/BANK_ROWS); bank depth = BANK_ROWS·2^XW.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_x  in  XW  write column.
- wr_y  in  YW  write row.
- wr_data  in  PIX_W  write pixel.
- wr_ready  out  1  write accepted when wr_en & wr_ready.
- rd_en  in  1  read request.
- rd_x  in  XW  read column.
- rd_y  in  YW  read row.
- rd_ready  out  1  read accepted when rd_en & rd_ready.
- rd_data  out  PIX_W  read pixel; 0 when rd_valid low.
- rd_valid  out  1  rd_data valid.
- fill_start  in  1  start-fill pulse.
- fill_color  in  PIX_W  colour sampled on accepted fill_start.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse at fill completion.

## Operation
- Bank select = y / BANK_ROWS; bank address = {y mod BANK_ROWS, x}.
- States: IDLE, FILL. Reset → IDLE.
- IDLE: rd_ready = 1. wr_ready = 0 only if rd_en and both requests target the same bank; otherwise 1. Read has priority (refresh must not stall).
- Different-bank read and write in the same cycle: both performed.
- Same address, different cycles: write at edge N visible to a read accepted at edge N+1 or later.
- Out-of-range (x ≥ WIDTH or y ≥ HEIGHT): write accepted and dropped; read accepted, returns rd_data = 0 with rd_valid = 1.
- IDLE + fill_start: latch fill_color, zero address counter, → FILL next cycle. rd/wr in the start cycle served normally.
- FILL: rd_ready = wr_ready = 0; every bank writes fill_color at the counter address each cycle; counter steps 0 … BANK_ROWS·WIDTH−1, skipping x ≥ WIDTH. The final-address cycle asserts fill_done and returns to IDLE. Fill duration = BANK_ROWS·WIDTH cycles (8192 at defaults).
- fill_start during FILL: ignored.
- Rows ≥ HEIGHT in the last bank may be written by fill; never readable.

## Timing
- Reset values: rd_valid 0, rd_data 0, fill_busy 0, fill_done 0; wr_ready/rd_ready follow state (IDLE → 1).
- Read latency 1: accepted at edge N → rd_valid = 1 and rd_data valid during cycle N..N+1; back-to-back reads give one result per cycle.
- wr_ready/rd_ready combinational from state, rd_en, rd_y, wr_y.
- fill_busy registered, high from the cycle after accepted fill_start through the last fill cycle inclusive.
- Reset mid-fill: immediate abort, → IDLE, fill_done not pulsed; RAM contents partially filled (undefined).
- Reset with a read in flight: rd_valid forced 0.

## Structure
- Shared package: derived widths XW, YW, NUM_BANKS, bank address width, state encoding.
- One sub-module: framebuffer_bank, a single-port sync RAM (1-cycle read, write-enable, PIX_W data), instantiated NUM_BANKS times; maps onto SB_SPRAM256KA when depth = 16K and PIX_W = 16.

## Test plan
- Write (5,3)=0xF800, then read (5,3) → rd_valid next cycle, rd_data = 0xF800.
- Same cycle rd (0,10), wr (1,20) same bank → wr_ready = 0, read completes; retried write accepted next cycle.
- Same cycle rd (0,10), wr (0,100) different banks → both accepted; later read (0,100) = written value.
- fill_start, color 0x07E0 → fill_busy for 8192 cycles, one fill_done pulse, ready low throughout; random reads afterwards all 0x07E0.
- Read (130,0) at WIDTH = 128 only reachable with XW = 8 configs (WIDTH = 130 build): out-of-range read → rd_data 0, rd_valid 1; out-of-range write leaves memory unchanged.
- Assert rst_n low mid-fill → fill_busy 0, no fill_done, rd_ready = 1 after release.
